accel_seq_ctrl: RTL and testbench
=================================

Name: accel_seq_ctrl

Overview:
- Avalon-MM slave controller that sequences the neural-network compute datapath layer by layer for the HPS.
- The host programs a layer count and writes START. The block issues one layer_start pulse per layer and waits for layer_done each time.
- It reports busy/done/timeout status, drives a level "ready" flag and an optional interrupt.
- It sits on the lightweight HPS bridge beside the existing PIO slaves.

Parameters:
- IDX_W, 8, width of layer count/index.
- CNT_W, 32, width of cycle counter.
- TIMEOUT_CYCLES, 1000000, max cycles per layer in WAIT before abort.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address
- layer_start  out  1  one-cycle pulse to datapath
- layer_idx  out  IDX_W  index of current layer, 0-based
- layer_done  in  1  datapath completion pulse
- ready  out  1  high when idle (not busy)
- irq  out  1  interrupt, level

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, on reset_n. Write accepted when chipselect && !write_n. Read data has 0 wait states.
- Register map:
  - 0 CTRL: W bit0 START (self-clearing, reads 0), bit1 IRQ_EN (stored), bit2 ABORT (self-clearing). R bit1 IRQ_EN.
  - 1 STATUS: R bit0 busy, bit1 done, bit2 timeout. done and timeout are sticky, write-1-to-clear.
  - 2 LAYER_CNT: RW, low IDX_W bits, zero-extended on read.
  - 3 CYCLES: RO, cycle count of the last/current run.
- Reset values: all registers 0, state IDLE, layer_start=0, layer_idx=0, ready=1, irq=0, readdata reflects zeroed registers.
- FSM states: IDLE, START, WAIT, DONE.
  - IDLE: START write with LAYER_CNT!=0 -> START. The same write clears done/timeout and clears CYCLES; layer_idx=0. START with LAYER_CNT==0 is ignored.
  - START: layer_start=1 for exactly this cycle; per-layer timer cleared -> WAIT.
  - WAIT: layer_done=1 -> if layer_idx==LAYER_CNT-1 go DONE, else layer_idx+1 and go START. Timer reaching TIMEOUT_CYCLES-1 without done -> set timeout, go IDLE.
  - DONE: set done, go IDLE (1 cycle).
- busy = (state!=IDLE); ready = !busy, registered with the state.
- CYCLES increments every cycle while busy and saturates at all-ones.
- irq = IRQ_EN && (done || timeout). Cleared by W1C of both flags or IRQ_EN=0.
- Boundary cases:
  - START while busy: ignored.
  - LAYER_CNT write while busy: ignored; value is latched at start.
  - ABORT while busy: -> IDLE next cycle; layer_idx held; no done/timeout set; no further layer_start. ABORT in IDLE: no effect.
  - START and ABORT in the same write: ABORT wins.
  - layer_done outside WAIT: ignored.
  - layer_done in the same cycle as timeout expiry: done wins.
  - W1C of done in the same cycle as DONE sets it: set wins.
  - Reset mid-run: immediate return to reset values; layer_start deasserted.
- Latency: START write at cycle n -> layer_start high at n+1. layer_done at cycle m -> next layer_start at m+2.

Decomposition:
- Shared package accel_pkg:
  - state enum (IDLE/START/WAIT/DONE)
  - register address constants (CTRL=0, STATUS=1, LAYER_CNT=2, CYCLES=3)
  - CTRL/STATUS bit position constants
- Sub-module seq_timeout_cnt: per-layer timeout counter with clear and expiry flag.
- Register file and FSM stay in the top level.

Test Plan:
- Reset -> readdata 0 at all addresses, ready=1, irq=0, layer_start=0.
- LAYER_CNT=3, CTRL=0x3; datapath returns layer_done 5 cycles after each start -> 3 layer_start pulses with layer_idx 0,1,2. Then done=1, irq=1, ready=1, and CYCLES equals the busy-cycle total.
- TIMEOUT_CYCLES=16 in bench, LAYER_CNT=2, no layer_done -> timeout=1 after 16 WAIT cycles, done=0, returns IDLE. W1C STATUS=0x4 clears it and irq drops.
- START with LAYER_CNT=0 -> no layer_start, busy stays 0. START while busy -> pulse count unchanged.
- ABORT during WAIT of layer 1 of 4 -> IDLE next cycle, no done, no further pulses. A subsequent START restarts at layer_idx 0.
- layer_done on the exact timeout-expiry cycle -> layer completes, timeout=0. Reset asserted mid-WAIT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and register map for the layer sequencer.
package accel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam logic [1:0] ADDR_CTRL      = 2'd0;
   localparam logic [1:0] ADDR_STATUS    = 2'd1;
   localparam logic [1:0] ADDR_LAYER_CNT = 2'd2;
   localparam logic [1:0] ADDR_CYCLES    = 2'd3;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_ABORT   = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TIMEOUT = 2;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Per-layer watchdog: down-counter loaded on clr, terminal count flags expiry.
module seq_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   // Holds at zero so a late done can still be honoured on the expiry cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= LOAD;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/accel_seq_ctrl.sv
// Avalon-MM layer sequencer: issues one layer_start per layer and waits for
// layer_done, with per-layer timeout, abort, sticky status and cycle count.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | not busy, ready=1, waiting for a START write
// ST_START | layer_start pulse for layer_idx, watchdog reloaded
// ST_WAIT  | waiting for layer_done (one extra cycle to advance after it)
// ST_DONE  | all layers finished, done flag set on exit
module accel_seq_ctrl
   import accel_pkg::*;
#(
   parameter int unsigned IDX_W          = 8,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             layer_start,
   output logic [IDX_W-1:0] layer_idx,
   input  logic             layer_done,
   output logic             ready,
   output logic             irq
);

   seq_state_e       state, state_nx;
   logic [IDX_W-1:0] layer_cnt, idx;
   logic [CNT_W-1:0] cycles;
   logic             irq_en, done_flag, timeout_flag, adv_pend;
   logic             wr_en, wr_ctrl, wr_status, start_req, abort_req, start_ok;
   logic             set_done, set_timeout, idx_inc, last_layer, busy;
   logic             tmr_clr, tmr_en, tmr_expired;
   logic             unused_wdata;

   assign wr_en     = chipselect && !write_n;
   assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
   assign wr_status = wr_en && (address == ADDR_STATUS);
   assign start_req = wr_ctrl && writedata[CTRL_START];
   assign abort_req = wr_ctrl && writedata[CTRL_ABORT];
   assign start_ok  = (state == ST_IDLE) && start_req && !abort_req && (layer_cnt != '0);
   assign last_layer = (idx == (layer_cnt - IDX_W'(1)));
   assign busy      = (state != ST_IDLE);
   assign unused_wdata = ^writedata[31:IDX_W];

   seq_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   assign tmr_clr = (state == ST_START);
   assign tmr_en  = (state == ST_WAIT) && !adv_pend;

   always_comb begin
      state_nx    = state;
      set_done    = 1'b0;
      set_timeout = 1'b0;
      idx_inc     = 1'b0;
      case (state)
         ST_IDLE:  if (start_ok) state_nx = ST_START;
         ST_START: state_nx = abort_req ? ST_IDLE : ST_WAIT;
         ST_WAIT: begin
            if (abort_req) begin
               state_nx = ST_IDLE;
            end else if (adv_pend) begin
               if (last_layer) begin
                  state_nx = ST_DONE;
               end else begin
                  idx_inc  = 1'b1;
                  state_nx = ST_START;
               end
            end else if (!layer_done && tmr_expired) begin
               set_timeout = 1'b1;
               state_nx    = ST_IDLE;
            end
         end
         ST_DONE: begin
            set_done = !abort_req;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // adv_pend spends one cycle after layer_done before the next layer starts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         adv_pend <= 1'b0;
         idx      <= '0;
      end else begin
         state    <= state_nx;
         adv_pend <= (state == ST_WAIT) && !adv_pend && !abort_req && layer_done;
         if (start_ok) begin
            idx <= '0;
         end else if (idx_inc) begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en       <= 1'b0;
         layer_cnt    <= '0;
         done_flag    <= 1'b0;
         timeout_flag <= 1'b0;
         cycles       <= '0;
      end else begin
         if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
         if (wr_en && (address == ADDR_LAYER_CNT) && !busy) layer_cnt <= writedata[IDX_W-1:0];

         if (set_done) begin
            done_flag <= 1'b1;
         end else if (start_ok || (wr_status && writedata[STAT_DONE])) begin
            done_flag <= 1'b0;
         end

         if (set_timeout) begin
            timeout_flag <= 1'b1;
         end else if (start_ok || (wr_status && writedata[STAT_TIMEOUT])) begin
            timeout_flag <= 1'b0;
         end

         if (start_ok) begin
            cycles <= '0;
         end else if (busy && (cycles != '1)) begin
            cycles <= cycles + CNT_W'(1);
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:      readdata[CTRL_IRQ_EN] = irq_en;
         ADDR_STATUS: begin
            readdata[STAT_BUSY]    = busy;
            readdata[STAT_DONE]    = done_flag;
            readdata[STAT_TIMEOUT] = timeout_flag;
         end
         ADDR_LAYER_CNT: readdata[IDX_W-1:0] = layer_cnt;
         ADDR_CYCLES:    readdata = 32'(cycles);
         default:        readdata = '0;
      endcase
   end

   assign layer_start = (state == ST_START);
   assign layer_idx   = idx;
   assign ready       = !busy;
   assign irq         = irq_en && (done_flag || timeout_flag);

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Randomized bench for accel_seq_ctrl against a per-layer latency model.
module tb_accel_seq_ctrl;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        layer_start;
   logic [7:0]  layer_idx;
   logic        layer_done = 1'b0;
   logic        ready;
   logic        irq;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  pulse_q[$];
   int          lat_tab[256];

   accel_seq_ctrl #(.IDX_W(8), .CNT_W(32), .TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .layer_start (layer_start),
      .layer_idx   (layer_idx),
      .layer_done  (layer_done),
      .ready       (ready),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Datapath stand-in: layer_done lat_tab[idx] cycles after each start (0 = never).
   initial begin
      int cd;
      cd = 0;
      forever begin
         @(negedge clk);
         layer_done = 1'b0;
         if (!reset_n) begin
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) layer_done = 1'b1;
            end
            if (layer_start === 1'b1 && lat_tab[layer_idx] > 0) cd = lat_tab[layer_idx];
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && layer_start === 1'b1) pulse_q.push_back(layer_idx);
      end
   end

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (ready === 1'b1) break;
         @(negedge clk);
      end
      check_val("run_end_ready", 32'(ready), 32'd1);
   endtask

   task automatic wait_pulses(input int k, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pulse_q.size() >= k) break;
         @(negedge clk);
      end
      check_val("pulse_wait", 32'(pulse_q.size() >= k), 32'd1);
   endtask

   // Each completed layer costs latency+2 cycles, DONE adds 1, a stalled layer costs 1+T.
   task automatic model_run(input int n, output int ep, output int ec, output bit ed, output bit et);
      ep = n; ec = 0; ed = 1'b0; et = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (lat_tab[i] == 0 || lat_tab[i] > T) begin
            ep = i + 1;
            ec += 1 + T;
            et = 1'b1;
            return;
         end
         ec += lat_tab[i] + 2;
      end
      ec += 1;
      ed = 1'b1;
   endtask

   task automatic run_and_check(input int n, input bit ien);
      int ep, ec;
      bit ed, et;
      logic [31:0] rd;
      model_run(n, ep, ec, ed, et);
      pulse_q.delete();
      bus_wr(2'd2, 32'(n));
      bus_wr(2'd0, {30'd0, ien, 1'b1});
      check_val("start_latency", 32'(layer_start), 32'd1);
      bus_rd(2'd1, rd);
      check_val("busy_status", rd, 32'd1);
      wait_idle(2000);
      check_val("pulse_count", 32'(pulse_q.size()), 32'(ep));
      for (int i = 0; i < ep && i < pulse_q.size(); i++) check_val("pulse_idx", 32'(pulse_q[i]), 32'(i));
      bus_rd(2'd1, rd);
      check_val("status_end", rd, {29'd0, et, ed, 1'b0});
      bus_rd(2'd3, rd);
      check_val("cycles", rd, 32'(ec));
      check_val("irq_end", 32'(irq), 32'(ien & (ed | et)));
   endtask

   initial begin
      logic [31:0] rd;
      int          n;
      bit          ien;

      repeat (3) @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a), rd);
         check_val("reset_rd", rd, 32'd0);
      end
      check_val("reset_ready", 32'(ready), 32'd1);
      check_val("reset_irq", 32'(irq), 32'd0);
      check_val("reset_lstart", 32'(layer_start), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("post_reset_idx", 32'(layer_idx), 32'd0);

      for (int i = 0; i < 256; i++) lat_tab[i] = 5;
      run_and_check(3, 1'b1);
      bus_rd(2'd2, rd);
      check_val("layer_cnt_rd", rd, 32'd3);
      bus_rd(2'd0, rd);
      check_val("ctrl_rd", rd, 32'd2);
      bus_wr(2'd0, 32'd0);
      check_val("irq_en_off", 32'(irq), 32'd0);
      bus_wr(2'd0, 32'd2);
      check_val("irq_en_on", 32'(irq), 32'd1);
      bus_wr(2'd1, 32'd2);
      bus_rd(2'd1, rd);
      check_val("w1c_done", rd, 32'd0);
      check_val("w1c_done_irq", 32'(irq), 32'd0);

      for (int i = 0; i < 256; i++) lat_tab[i] = 0;
      run_and_check(2, 1'b1);
      bus_wr(2'd1, 32'd4);
      bus_rd(2'd1, rd);
      check_val("w1c_timeout", rd, 32'd0);
      check_val("w1c_timeout_irq", 32'(irq), 32'd0);

      lat_tab[0] = T; lat_tab[1] = T;
      run_and_check(2, 1'b0);

      for (int r = 0; r < 8; r++) begin
         n   = $urandom_range(1, 5);
         ien = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++)
            lat_tab[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(T + 1, T + 4) : $urandom_range(1, T);
         run_and_check(n, ien);
         repeat (25) @(negedge clk);
      end

      pulse_q.delete();
      bus_wr(2'd2, 32'd0);
      bus_wr(2'd0, 32'd1);
      check_val("zero_cnt_ready", 32'(ready), 32'd1);
      repeat (5) @(negedge clk);
      check_val("zero_cnt_pulses", 32'(pulse_q.size()), 32'd0);
      bus_rd(2'd1, rd);
      check_val("zero_cnt_busy", rd & 32'd1, 32'd0);

      bus_wr(2'd2, 32'd3);
      bus_wr(2'd0, 32'd5);
      check_val("start_abort_ready", 32'(ready), 32'd1);
      repeat (5) @(negedge clk);
      check_val("start_abort_pulses", 32'(pulse_q.size()), 32'd0);

      for (int i = 0; i < 256; i++) lat_tab[i] = 6;
      pulse_q.delete();
      bus_wr(2'd2, 32'd2);
      bus_wr(2'd0, 32'd1);
      repeat (3) @(negedge clk);
      bus_wr(2'd0, 32'd1);
      bus_wr(2'd2, 32'd7);
      wait_idle(500);
      check_val("busy_start_pulses", 32'(pulse_q.size()), 32'd2);
      bus_rd(2'd2, rd);
      check_val("busy_cnt_write", rd, 32'd2);
      bus_rd(2'd3, rd);
      check_val("busy_cycles", rd, 32'd17);

      for (int i = 0; i < 256; i++) lat_tab[i] = 8;
      pulse_q.delete();
      bus_wr(2'd2, 32'd4);
      bus_wr(2'd0, 32'd1);
      wait_pulses(2, 200);
      repeat (3) @(negedge clk);
      bus_wr(2'd0, 32'd4);
      check_val("abort_ready", 32'(ready), 32'd1);
      check_val("abort_idx_held", 32'(layer_idx), 32'd1);
      repeat (20) @(negedge clk);
      check_val("abort_pulses", 32'(pulse_q.size()), 32'd2);
      bus_rd(2'd1, rd);
      check_val("abort_status", rd, 32'd0);
      for (int i = 0; i < 256; i++) lat_tab[i] = 3;
      run_and_check(4, 1'b0);

      lat_tab[0] = 3; lat_tab[1] = 0;
      pulse_q.delete();
      bus_wr(2'd2, 32'd3);
      bus_wr(2'd0, 32'd3);
      wait_pulses(2, 200);
      repeat (3) @(negedge clk);
      check_val("pre_reset_busy", 32'(ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check_val("rst_ready", 32'(ready), 32'd1);
      check_val("rst_lstart", 32'(layer_start), 32'd0);
      check_val("rst_idx", 32'(layer_idx), 32'd0);
      check_val("rst_irq", 32'(irq), 32'd0);
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a), rd);
         check_val("rst_rd", rd, 32'd0);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
